// File: rtl/display_pkg.sv
// Shared types and segment constants for the LED BCD display.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } conv_state_t;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [31:0] DISP_MAX = 32'd9999;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        return (d <= 4'd9) ? SEG_DIGIT[d] : SEG_BLANK;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: IDLE -> SHIFT (IN_W cycles) -> LOAD.
// Emits the 4-nibble BCD word with a one-cycle load strobe.
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int IN_W = 14
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IN_W-1:0] i_value,
    output logic            o_busy,
    output logic            o_overflow,
    output logic [15:0]     o_bcd,
    output logic            o_load
);

    localparam int CNT_W = $clog2(IN_W);

    conv_state_t     r_state;
    logic [IN_W-1:0] r_shown_bin;
    logic [IN_W-1:0] r_bin;
    logic [15:0]     r_bcd;
    logic [CNT_W-1:0] r_cnt;
    logic            r_overflow;
    logic [15:0]     w_adj;

    always_comb begin
        w_adj = r_bcd;
        for (int k = 0; k < 4; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5)
                w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_shown_bin <= '0;
            r_bin       <= '0;
            r_bcd       <= '0;
            r_cnt       <= '0;
            r_overflow  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_value != r_shown_bin) begin
                        r_bin       <= i_value;
                        r_shown_bin <= i_value;
                        r_bcd       <= '0;
                        r_cnt       <= '0;
                        r_state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
                    r_cnt          <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(IN_W - 1))
                        r_state <= LOAD;
                end
                LOAD: begin
                    r_overflow <= (32'(r_shown_bin) > DISP_MAX);
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy     = (r_state != IDLE);
    assign o_load     = (r_state == LOAD);
    assign o_bcd      = r_bcd;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/led_bcd_display.sv
// 4-digit multiplexed active-low 7-segment driver fed by bin2bcd_seq.
// Define LED_BCD_LZB_EN to blank leading zeros (digit 0 always shown).
module led_bcd_display
    import display_pkg::*;
#(
    parameter int IN_W     = 14,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IN_W-1:0]   value,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              busy,
    output logic              overflow
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = $clog2(DIGITS);

    logic [SCAN_W-1:0]           r_scan_cnt;
    logic [IDX_W-1:0]            r_idx;
    logic                        r_scan_on;
    logic [DIGITS-1:0][3:0]      r_digits;
    logic [6:0]                  r_seg;
    logic [DIGITS-1:0]           r_an;

    logic                        w_wrap;
    logic                        w_on_nxt;
    logic [IDX_W-1:0]            w_idx_nxt;
    logic [6:0]                  w_seg_nxt;
    logic [15:0]                 w_bcd;
    logic                        w_load;
    logic                        w_overflow;

    bin2bcd_seq #(.IN_W(IN_W)) u_conv (
        .clk        (clk),
        .reset      (reset),
        .i_value    (value),
        .o_busy     (busy),
        .o_overflow (w_overflow),
        .o_bcd      (w_bcd),
        .o_load     (w_load)
    );

    assign w_wrap   = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));
    // The first wrap only turns the display on, so digit 0 is shown first.
    assign w_on_nxt = r_scan_on | w_wrap;

    always_comb begin
        w_idx_nxt = r_idx;
        if (w_wrap && r_scan_on)
            w_idx_nxt = (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end

`ifdef LED_BCD_LZB_EN
    logic [DIGITS-1:0] w_lz;
    // w_lz[k]: digits k..DIGITS-1 are all zero
    always_comb begin
        w_lz = '0;
        w_lz[DIGITS-1] = (r_digits[DIGITS-1] == 4'd0);
        for (int k = DIGITS - 2; k >= 0; k--)
            w_lz[k] = w_lz[k+1] & (r_digits[k] == 4'd0);
    end
`endif

    always_comb begin
        w_seg_nxt = seg_of(r_digits[w_idx_nxt]);
`ifdef LED_BCD_LZB_EN
        if (w_idx_nxt != '0 && w_lz[w_idx_nxt])
            w_seg_nxt = SEG_BLANK;
`endif
        if (w_overflow)
            w_seg_nxt = SEG_DASH;
        if (!w_on_nxt)
            w_seg_nxt = SEG_BLANK;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_scan_on  <= 1'b0;
            r_digits   <= '0;
            r_seg      <= SEG_BLANK;
            r_an       <= '1;
        end else begin
            r_scan_cnt <= w_wrap ? '0 : r_scan_cnt + 1'b1;
            r_idx      <= w_idx_nxt;
            r_scan_on  <= w_on_nxt;
            if (w_load)
                r_digits <= w_bcd;
            r_seg      <= w_seg_nxt;
            r_an       <= w_on_nxt ? ~(DIGITS'(1) << w_idx_nxt) : '1;
        end
    end

    assign seg      = r_seg;
    assign an       = r_an;
    assign overflow = w_overflow;

endmodule

// File: tb/tb_led_bcd_display.sv
// Self-checking bench for led_bcd_display with a fast scan (SCAN_DIV = 4).
module tb_led_bcd_display;

    localparam int IN_W     = 14;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [IN_W-1:0] value = '0;
    logic [6:0]      seg;
    logic [3:0]      an;
    logic            busy;
    logic            overflow;

    int checks = 0;
    int failures = 0;

    led_bcd_display #(.IN_W(IN_W), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .seg      (seg),
        .an       (an),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] SEGS [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // Reference: decimal digit idx of v, dashes above 9999, optional blanking
    function automatic logic [6:0] exp_seg(int v, int idx);
        int p = 1;
        for (int i = 0; i < idx; i++) p = p * 10;
        if (v > 9999) return 7'h3F;
`ifdef LED_BCD_LZB_EN
        if (idx > 0 && v < p) return 7'h7F;
`endif
        return SEGS[(v / p) % 10];
    endfunction

    function automatic int an_idx(logic [3:0] a);
        case (a)
            4'hE: return 0;
            4'hD: return 1;
            4'hB: return 2;
            4'h7: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_display(int v, string tag);
        int seen = 0;
        int k;
        for (int c = 0; c < DIGITS * SCAN_DIV; c++) begin
            k = an_idx(an);
            chk({tag, "_an_onehot"}, 32'(k >= 0), 1);
            if (k >= 0) begin
                chk({tag, "_seg"}, seg, exp_seg(v, k));
                seen = seen | (1 << k);
            end
            tick();
        end
        chk({tag, "_all_digits"}, seen, 15);
    endtask

    task automatic wait_conv(int v, string tag);
        for (int i = 1; i <= IN_W + 1; i++) begin
            tick();
            chk({tag, "_busy"}, busy, 1);
        end
        tick();
        chk({tag, "_busy_done"}, busy, 0);
        chk({tag, "_ovf"}, overflow, 32'(v > 9999));
        tick();
        tick();
        check_display(v, tag);
    endtask

    task automatic convert(int v, string tag);
        value = IN_W'(v);
        wait_conv(v, tag);
    endtask

    initial begin
        int v;
        int last;
        int k;
        logic [3:0] exp_an;

        // Reset with value 0: blank until first wrap, then scan zeros
        reset = 1'b1;
        value = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        for (int c = 0; c < 20; c++) begin
            exp_an = (c < 4) ? 4'hF : ~(4'b1 << (((c - 4) / 4) % 4));
            chk("scan_an", an, exp_an);
            chk("scan_seg", seg, (c < 4) ? 7'h7F : exp_seg(0, ((c - 4) / 4) % 4));
            chk("scan_busy", busy, 0);
            tick();
        end

        convert(1234, "v1234");
        convert(9999, "v9999");
        convert(10000, "v10000");
        convert(16383, "v16383");

        // Change during SHIFT is ignored until the running conversion ends
        value = IN_W'(1234);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("mid_busy1", busy, 1);
        end
        value = IN_W'(42);
        for (int i = 6; i <= 15; i++) begin
            tick();
            chk("mid_busy1", busy, 1);
        end
        tick();
        chk("mid_gap", busy, 0);
        chk("mid_ovf", overflow, 0);
        tick();
        chk("mid_busy2_start", busy, 1);
        k = an_idx(an);
        chk("mid_first_onehot", 32'(k >= 0), 1);
        if (k >= 0) chk("mid_first_1234", seg, exp_seg(1234, k));
        for (int i = 2; i <= 15; i++) begin
            tick();
            chk("mid_busy2", busy, 1);
        end
        tick();
        chk("mid_busy2_done", busy, 0);
        tick();
        tick();
        check_display(42, "v42");

        convert(12000, "v12000");

        // Reset in the 7th SHIFT cycle aborts; 555 then converts fresh
        value = IN_W'(555);
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("abort_busy", busy, 1);
        end
        reset = 1'b1;
        tick();
        chk("abort_busy0", busy, 0);
        chk("abort_an", an, 4'hF);
        chk("abort_seg", seg, 7'h7F);
        chk("abort_ovf", overflow, 0);
        reset = 1'b0;
        wait_conv(555, "v555");
        last = 555;

        for (int r = 0; r < 6; r++) begin
            v = $urandom_range(10, 16383);
            if (v == last) v = (v == 16383) ? 10 : v + 1;
            convert(v, "rand");
            last = v;
        end

        convert(7, "v7");
        convert(0, "v0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
